if_branch_stash: RTL and testbench

- In-order FIFO of in-flight conditional branches, between IF (producer of predictions) and EX (branch resolution).
- IF pushes each predicted branch: PC, taken-target, predicted direction. EX resolves the oldest entry.
- On each resolve the block drives the GShare predictor's training interface (pc_jmp_feedback / pc_jmp_take / pc_stash_base).
- On a misprediction it issues a PC redirect and squashes all younger entries.

---
 rtl/if_branch_stash_pkg.sv | 26 ++
 rtl/if_branch_stash_fifo.sv | 66 ++++++
 rtl/if_branch_stash.sv | 81 ++++++++
 tb/tb_if_branch_stash.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_branch_stash_pkg.sv
// Shared branch-prediction types and constants, used by the stash and the predictor.
package if_branch_stash_pkg;

    localparam int          PC_W       = 32;
    localparam logic [31:0] INSTR_STEP = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            pred;
    } stash_entry_t;

    // 2-bit saturating counter encodings used by the GShare tables.
    typedef enum logic [1:0] {
        NTAKE       = 2'b00,
        TAKE        = 2'b01,
        NTAKE_NTAKE = 2'b10,
        TAKE_TAKE   = 2'b11
    } bp_cnt_e;

    // Fall-through PC of a branch; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + INSTR_STEP;
    endfunction

endpackage

// File: rtl/if_branch_stash_fifo.sv
// Generic circular buffer of stash entries with push, pop and clear.
// A clear in the same cycle as a pop leaves the buffer empty at the popped position.
module if_branch_stash_fifo
    import if_branch_stash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  stash_entry_t     push_data,
    input  logic             pop,
    input  logic             clear,
    output stash_entry_t     head_data,
    output logic             head_valid,
    output logic [PTR_W:0]   count
);

    stash_entry_t     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_next;
    logic             wr;
    logic [PTR_W:0]   count_next;

    assign wr         = push && !clear;
    assign head_next  = pop ? head + PTR_W'(1) : head;
    assign count_next = count + {{PTR_W{1'b0}}, wr} - {{PTR_W{1'b0}}, pop};
    assign head_data  = mem[head];
    assign head_valid = valid[head];

    // Entry payload storage; not reset, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer, occupancy and per-entry valid tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else if (clear) begin
            head  <= head_next;
            tail  <= head_next;
            count <= '0;
            valid <= '0;
        end else begin
            head  <= head_next;
            count <= count_next;
            if (pop) begin
                valid[head] <= 1'b0;
            end
            if (wr) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_branch_stash.sv
// In-order stash of in-flight conditional branches between IF and EX.
// Trains the predictor on every resolve and redirects fetch on a mispredict.
module if_branch_stash
    import if_branch_stash_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_target,
    input  logic             push_pred,
    output logic             full,
    input  logic             resolve_valid,
    input  logic             resolve_take,
    input  logic             flush,
    output logic             pc_jmp_feedback,
    output logic             pc_jmp_take,
    output logic [31:0]      pc_stash_base,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    stash_entry_t push_entry;
    stash_entry_t head_entry;
    logic         head_valid;
    logic         push_ok;
    logic         resolve_ok;
    logic         mispredict;

    // full reflects start-of-cycle occupancy, so a push while full is dropped
    // even if a resolve frees a slot in the same cycle.
    assign full       = (count == DEPTH_C);
    assign push_ok    = push_valid && !full && !flush;
    assign resolve_ok = resolve_valid && (count != '0) && head_valid && !flush;
    assign mispredict = resolve_ok && (resolve_take != head_entry.pred);

    assign push_entry = '{pc: push_pc, target: push_target, pred: push_pred};

    if_branch_stash_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_ok),
        .push_data  (push_entry),
        .pop        (resolve_ok),
        .clear      (flush || mispredict),
        .head_data  (head_entry),
        .head_valid (head_valid),
        .count      (count)
    );

    // Registered training and redirect strobes, one cycle after the resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_jmp_feedback <= 1'b0;
            pc_jmp_take     <= 1'b0;
            pc_stash_base   <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            pc_jmp_feedback <= resolve_ok;
            redirect_valid  <= mispredict;
            if (resolve_ok) begin
                pc_jmp_take   <= resolve_take;
                pc_stash_base <= head_entry.pc;
            end
            if (mispredict) begin
                redirect_pc <= resolve_take ? head_entry.target : next_seq_pc(head_entry.pc);
            end
        end
    end

endmodule

// File: tb/tb_if_branch_stash.sv
// Directed bench for if_branch_stash with hand-computed expectations.
module tb_if_branch_stash;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_target;
    logic        push_pred;
    logic        full;
    logic        resolve_valid;
    logic        resolve_take;
    logic        flush;
    logic        pc_jmp_feedback;
    logic        pc_jmp_take;
    logic [31:0] pc_stash_base;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    if_branch_stash #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_pc         (push_pc),
        .push_target     (push_target),
        .push_pred       (push_pred),
        .full            (full),
        .resolve_valid   (resolve_valid),
        .resolve_take    (resolve_take),
        .flush           (flush),
        .pc_jmp_feedback (pc_jmp_feedback),
        .pc_jmp_take     (pc_jmp_take),
        .pc_stash_base   (pc_stash_base),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
        resolve_take  = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        push_valid  = 1'b1;
        push_pc     = pc;
        push_target = tgt;
        push_pred   = pred;
        step();
        push_valid  = 1'b0;
    endtask

    task automatic resolve_one(input logic take);
        resolve_valid = 1'b1;
        resolve_take  = take;
        step();
        resolve_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        push_pc     = '0;
        push_target = '0;
        push_pred   = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;

        check("rst_count",    32'(count), 32'd0);
        check("rst_full",     32'(full), 32'd0);
        check("rst_feedback", 32'(pc_jmp_feedback), 32'd0);
        check("rst_take",     32'(pc_jmp_take), 32'd0);
        check("rst_base",     pc_stash_base, 32'd0);
        check("rst_redir",    32'(redirect_valid), 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);

        // Correct taken prediction.
        push_one(32'h100, 32'h200, 1'b1);
        check("t1_count_push", 32'(count), 32'd1);
        resolve_one(1'b1);
        check("t1_feedback", 32'(pc_jmp_feedback), 32'd1);
        check("t1_take",     32'(pc_jmp_take), 32'd1);
        check("t1_base",     pc_stash_base, 32'h100);
        check("t1_redir",    32'(redirect_valid), 32'd0);
        check("t1_count",    32'(count), 32'd0);
        step();
        check("t1_fb_drop",  32'(pc_jmp_feedback), 32'd0);
        check("t1_base_hold", pc_stash_base, 32'h100);

        // Predicted taken, actually not taken: fall through to pc+4.
        push_one(32'h100, 32'h300, 1'b1);
        resolve_one(1'b0);
        check("t2_redir",    32'(redirect_valid), 32'd1);
        check("t2_redir_pc", redirect_pc, 32'h104);
        check("t2_feedback", 32'(pc_jmp_feedback), 32'd1);
        check("t2_take",     32'(pc_jmp_take), 32'd0);
        step();
        check("t2_redir_drop", 32'(redirect_valid), 32'd0);

        // Oldest predicted not-taken, actually taken: squash younger entries.
        push_one(32'h10, 32'h80, 1'b0);
        push_one(32'h20, 32'h90, 1'b0);
        push_one(32'h30, 32'hA0, 1'b0);
        check("t3_count3", 32'(count), 32'd3);
        resolve_one(1'b1);
        check("t3_redir",    32'(redirect_valid), 32'd1);
        check("t3_redir_pc", redirect_pc, 32'h80);
        check("t3_count0",   32'(count), 32'd0);
        resolve_one(1'b0);
        check("t3_empty_fb",    32'(pc_jmp_feedback), 32'd0);
        check("t3_empty_redir", 32'(redirect_valid), 32'd0);

        // Fill, drop the 5th push under a simultaneous correct resolve, drain in order.
        push_one(32'h10, 32'h110, 1'b0);
        push_one(32'h20, 32'h120, 1'b0);
        push_one(32'h30, 32'h130, 1'b0);
        push_one(32'h40, 32'h140, 1'b0);
        check("t4_full",   32'(full), 32'd1);
        check("t4_count4", 32'(count), 32'd4);
        push_valid  = 1'b1;
        push_pc     = 32'h50;
        push_target = 32'h150;
        push_pred   = 1'b0;
        resolve_one(1'b0);
        push_valid  = 1'b0;
        check("t4_count3", 32'(count), 32'd3);
        check("t4_notfull", 32'(full), 32'd0);
        check("t4_base0", pc_stash_base, 32'h10);
        check("t4_noredir", 32'(redirect_valid), 32'd0);
        resolve_one(1'b0);
        check("t4_base1", pc_stash_base, 32'h20);
        resolve_one(1'b0);
        check("t4_base2", pc_stash_base, 32'h30);
        resolve_one(1'b0);
        check("t4_base3", pc_stash_base, 32'h40);
        check("t4_drained", 32'(count), 32'd0);
        resolve_one(1'b0);
        check("t4_dropped", 32'(pc_jmp_feedback), 32'd0);

        // Fall-through address wraps at the top of the address space.
        push_one(32'hFFFF_FFFC, 32'h1000, 1'b1);
        resolve_one(1'b0);
        check("t5_redir",    32'(redirect_valid), 32'd1);
        check("t5_redir_pc", redirect_pc, 32'h0000_0000);

        // Correct resolve with a push: occupancy unchanged.
        push_one(32'h600, 32'h700, 1'b1);
        push_valid  = 1'b1;
        push_pc     = 32'h610;
        push_target = 32'h710;
        push_pred   = 1'b1;
        resolve_one(1'b1);
        push_valid  = 1'b0;
        check("t6_count", 32'(count), 32'd1);
        check("t6_base",  pc_stash_base, 32'h600);

        // Flush beats a same-cycle push and mispredicting resolve.
        push_one(32'h620, 32'h720, 1'b1);
        check("t7_count2", 32'(count), 32'd2);
        flush       = 1'b1;
        push_valid  = 1'b1;
        push_pc     = 32'h630;
        push_target = 32'h730;
        push_pred   = 1'b1;
        resolve_one(1'b0);
        flush       = 1'b0;
        push_valid  = 1'b0;
        check("t7_count0", 32'(count), 32'd0);
        check("t7_fb",     32'(pc_jmp_feedback), 32'd0);
        check("t7_redir",  32'(redirect_valid), 32'd0);
        push_one(32'h700, 32'h800, 1'b0);
        resolve_one(1'b0);
        check("t7_after_base", pc_stash_base, 32'h700);
        check("t7_after_cnt",  32'(count), 32'd0);

        // Reset with entries held and a mispredicting resolve pending.
        push_one(32'h900, 32'hA00, 1'b1);
        push_one(32'h910, 32'hA10, 1'b1);
        reset         = 1'b1;
        resolve_valid = 1'b1;
        resolve_take  = 1'b0;
        step();
        check("t8_count",    32'(count), 32'd0);
        check("t8_full",     32'(full), 32'd0);
        check("t8_fb",       32'(pc_jmp_feedback), 32'd0);
        check("t8_redir",    32'(redirect_valid), 32'd0);
        check("t8_redir_pc", redirect_pc, 32'd0);
        check("t8_base",     pc_stash_base, 32'd0);
        reset = 1'b0;
        idle();
        step();
        check("t8_fb_after", 32'(pc_jmp_feedback), 32'd0);
        check("t8_cnt_after", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
